// File: rtl/fetch_stage.sv
// fetch_stage: owns the fetch PC, samples I-cache words into a small FIFO for decode, handles redirects.
// Define FETCH_RVC_EN to enable 16-bit compressed instruction detection and 2-byte PC steps.
module fetch_stage #(
    parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] pc,
    input  logic [31:0] ir,
    input  logic        stall_imem,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_ir,
    output logic [63:0] id_pc,
    output logic        id_rvc,
    output logic        fetch_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = FIFO_DEPTH[PW:0];

    typedef enum logic {RUN, REDIR} state_t;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ir;
        logic        rvc;
    } entry_t;

    state_t        state;
    entry_t        mem [FIFO_DEPTH];
    entry_t        head_e;
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;
    logic [63:0]   rd_pc, tgt;
    logic [31:0]   ir_w;
    logic          rd_pend, pop, fetch, rvc;

`ifdef FETCH_RVC_EN
    assign rvc  = ir[1:0] != 2'b11;
    assign ir_w = rvc ? {16'b0, ir[15:0]} : ir;
    assign tgt  = redirect_pc & ~64'h1;
`else
    assign rvc  = 1'b0;
    assign ir_w = ir;
    assign tgt  = redirect_pc & ~64'h3;
`endif

    assign rd_pend    = state == REDIR;
    assign head_e     = mem[head];
    assign id_valid   = count != '0;
    assign id_ir      = head_e.ir;
    assign id_pc      = head_e.pc;
    assign id_rvc     = head_e.rvc;
    assign pop        = id_valid && id_ready;
    assign fetch      = !stall_imem && !rd_pend && (count != FULL || pop);
    assign fetch_busy = stall_imem || rd_pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (fetch) begin
                mem[tail] <= entry_t'{pc: pc, ir: ir_w, rvc: rvc};
                tail      <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
            count <= count + (PW+1)'(fetch) - (PW+1)'(pop);
        end
    end

    // A redirect during a stall is parked in rd_pc so the refill completes at the old pc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= RESET_VECTOR;
            rd_pc <= '0;
            state <= RUN;
        end else if (redirect) begin
            if (stall_imem) begin
                rd_pc <= tgt;
                state <= REDIR;
            end else begin
                pc    <= tgt;
                state <= RUN;
            end
        end else if (rd_pend && !stall_imem) begin
            pc    <= rd_pc;
            state <= RUN;
        end else if (fetch) begin
            pc <= pc + (rvc ? 64'd2 : 64'd4);
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_fetch_stage;
    localparam int DEPTH = 2;
`ifdef FETCH_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [63:0] pc, redirect_pc, id_pc;
    logic [31:0] ir, id_ir;
    logic        stall_imem, redirect, id_valid, id_ready, id_rvc, fetch_busy;
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    fetch_stage #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .ir(ir), .stall_imem(stall_imem),
        .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
        .id_ready(id_ready), .id_ir(id_ir), .id_pc(id_pc), .id_rvc(id_rvc),
        .fetch_busy(fetch_busy)
    );

    typedef struct { logic [63:0] pc; logic [31:0] ir; bit rvc; } ent_t;
    typedef struct { bit rs; bit rdy; logic [63:0] e_pc; bit e_v; logic [63:0] e_idpc; } vec_t;

    ent_t        q[$];
    logic [63:0] m_pc, m_tgt;
    bit          m_pend;
    vec_t        tbl[12];

    function automatic bit is_rvc(input logic [31:0] w);
        return RVC && (w[1:0] != 2'b11);
    endfunction

    function automatic logic [63:0] align(input logic [63:0] a);
        return a & (RVC ? ~64'h1 : ~64'h3);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit pop;
        pop = q.size() != 0 && id_ready;
        if (redirect) begin
            q.delete();
            if (stall_imem) begin
                m_pend = 1'b1;
                m_tgt  = align(redirect_pc);
            end else begin
                m_pend = 1'b0;
                m_pc   = align(redirect_pc);
            end
        end else if (m_pend) begin
            if (!stall_imem) begin
                m_pend = 1'b0;
                m_pc   = m_tgt;
            end
        end else begin
            if (pop) void'(q.pop_front());
            if (!stall_imem && q.size() < DEPTH) begin
                bit c;
                c = is_rvc(ir);
                q.push_back(ent_t'{m_pc, c ? {16'h0, ir[15:0]} : ir, c});
                m_pc += c ? 64'd2 : 64'd4;
            end
        end
    endtask

    task automatic model_check();
        chk("pc", pc, m_pc);
        chk("id_valid", id_valid, q.size() != 0);
        chk("fetch_busy", fetch_busy, stall_imem || m_pend);
        if (q.size() != 0) begin
            chk("id_pc", id_pc, q[0].pc);
            chk("id_ir", id_ir, q[0].ir);
            chk("id_rvc", id_rvc, q[0].rvc);
        end
    endtask

    task automatic drive(input bit s, input logic [31:0] w, input bit r, input logic [63:0] t, input bit rdy);
        stall_imem  = s;
        ir          = w;
        redirect    = r;
        redirect_pc = t;
        id_ready    = rdy;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input bit s, input logic [31:0] w, input bit r, input logic [63:0] t, input bit rdy);
        drive(s, w, r, t, rdy);
        #1;
        model_check();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive(1'b0, 32'h13, 1'b0, 64'h0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_pc", pc, 64'h8000_0000);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_ir", id_ir, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_rvc", id_rvc, 0);
        chk("rst_fetch_busy", fetch_busy, 0);
        rst_n = 1'b1;
        q.delete();
        m_pc   = 64'h8000_0000;
        m_pend = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
        tbl[1]  = '{1'b0, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000};
        tbl[2]  = '{1'b0, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004};
        tbl[3]  = '{1'b0, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008};
        tbl[4]  = '{1'b1, 1'b0, 64'h8000_0000, 1'b0, 64'h0};
        tbl[5]  = '{1'b0, 1'b0, 64'h8000_0004, 1'b1, 64'h8000_0000};
        tbl[6]  = '{1'b0, 1'b0, 64'h8000_0008, 1'b1, 64'h8000_0000};
        tbl[7]  = '{1'b0, 1'b0, 64'h8000_0008, 1'b1, 64'h8000_0000};
        tbl[8]  = '{1'b0, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0000};
        tbl[9]  = '{1'b0, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0004};
        tbl[10] = '{1'b0, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0008};
        tbl[11] = '{1'b0, 1'b1, 64'h8000_0014, 1'b1, 64'h8000_000C};
        drive(1'b0, 32'h13, 1'b0, 64'h0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rs) reset_dut();
            drive(1'b0, 32'h13, 1'b0, 64'h0, tbl[i].rdy);
            #1;
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_valid", i), id_valid, tbl[i].e_v);
            if (tbl[i].e_v) begin
                chk($sformatf("tbl%0d_id_pc", i), id_pc, tbl[i].e_idpc);
                chk($sformatf("tbl%0d_id_ir", i), id_ir, 32'h13);
            end
            tick();
        end

        // stalled redirect: pc held, FIFO flushed next cycle, target applied after stall drops
        reset_dut();
        apply(1'b0, 32'h13, 1'b0, 64'h0, 1'b0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            apply(1'b1, $urandom, k == 3, 64'h8000_1000, 1'b0);
            chk("stall_pc_hold", pc, 64'h8000_0004);
            if (k == 4) chk("stall_flush_valid", id_valid, 0);
            tick();
        end
        apply(1'b0, 32'h13, 1'b0, 64'h0, 1'b0);
        chk("drop_pc", pc, 64'h8000_0004);
        chk("drop_busy", fetch_busy, 1);
        tick();
        apply(1'b0, 32'h13, 1'b0, 64'h0, 1'b0);
        chk("redir_pc", pc, 64'h8000_1000);
        tick();
        apply(1'b0, 32'h13, 1'b0, 64'h0, 1'b1);
        chk("redir_id_pc", id_pc, 64'h8000_1000);
        tick();

        // two redirects while stalled: last one wins
        reset_dut();
        apply(1'b0, 32'h13, 1'b0, 64'h0, 1'b1);
        tick();
        for (int k = 1; k <= 6; k++) begin
            apply(1'b1, $urandom, k == 2 || k == 4, k == 2 ? 64'h2000 : 64'h3000, 1'b1);
            tick();
        end
        apply(1'b0, 32'h13, 1'b0, 64'h0, 1'b1);
        tick();
        apply(1'b0, 32'h13, 1'b0, 64'h0, 1'b1);
        chk("last_redir_pc", pc, 64'h3000);
        tick();
        apply(1'b0, 32'h13, 1'b0, 64'h0, 1'b1);
        chk("last_redir_id_pc", id_pc, 64'h3000);
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 32'h13, 1'b0, 64'h0, 1'b1);
            tick();
        end

        // compressed step (or plain +4 without the feature)
        reset_dut();
        apply(1'b0, 32'h4501, 1'b0, 64'h0, 1'b1);
        chk("rvc_pc0", pc, 64'h8000_0000);
        tick();
        apply(1'b0, 32'h13, 1'b0, 64'h0, 1'b1);
        chk("rvc_pc1", pc, RVC ? 64'h8000_0002 : 64'h8000_0004);
        chk("rvc_id_ir", id_ir, 32'h4501);
        chk("rvc_id_rvc", id_rvc, RVC);
        tick();
        apply(1'b0, 32'h13, 1'b0, 64'h0, 1'b1);
        chk("rvc_pc2", pc, RVC ? 64'h8000_0006 : 64'h8000_0008);
        chk("rvc_id_rvc2", id_rvc, 0);
        tick();

        // full FIFO with push, pop and redirect together
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 32'h13, 1'b0, 64'h0, 1'b0);
            tick();
        end
        apply(1'b0, 32'h13, 1'b1, 64'h4000_0102, 1'b1);
        chk("full_valid", id_valid, 1);
        tick();
        apply(1'b0, 32'h13, 1'b0, 64'h0, 1'b0);
        chk("flush_valid", id_valid, 0);
        chk("flush_pc", pc, RVC ? 64'h4000_0102 : 64'h4000_0100);
        tick();

        // random traffic
        reset_dut();
        for (int k = 0; k < 3000; k++) begin
            apply($urandom_range(9) < 3, $urandom, $urandom_range(15) == 0,
                  {32'($urandom), 32'($urandom)}, $urandom_range(9) < 6);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage; sits directly upstream of the L1 instruction cache.
- Owns the architectural fetch PC and drives it to the cache. Samples the returned instruction word whenever the cache is not stalling.
- Buffers fetched instructions in a small FIFO. Presents them to decode through a valid/ready handshake.
- Handles branch/trap redirects without disturbing an in-flight cache refill.

Parameters:
- RESET_VECTOR, 64'h0000_0000_8000_0000: PC loaded on reset.
- FIFO_DEPTH, 2: fetch buffer entries; power of two, 2..8.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- pc  out  64  fetch address to L1 I-cache
- ir  in  32  instruction word from I-cache; valid only when stall_imem=0
- stall_imem  in  1  I-cache busy; pc must be held stable while high
- redirect  in  1  one-cycle pulse from execute/trap: change fetch stream
- redirect_pc  in  64  redirect target
- id_valid  out  1  id_* holds a valid instruction
- id_ready  in  1  decode accepts the head entry this cycle
- id_ir  out  32  instruction (compressed ones zero-extended in [15:0])
- id_pc  out  64  address of id_ir
- id_rvc  out  1  id_ir is a 16-bit compressed instruction
- fetch_busy  out  1  redirect pending or cache stalled (performance counter)

Behaviour:
- Reset: pc=RESET_VECTOR, FIFO empty, id_valid=0, id_ir=0, id_pc=0, id_rvc=0, fetch_busy=0, pending redirect cleared. Reset mid-refill simply reloads pc; the cache resets on the same rst_n.
- Push condition: fetch = !stall_imem && !rd_pend && (count<FIFO_DEPTH || pop).
  - pop = id_valid && id_ready.
  - Push and pop in the same cycle on a full FIFO are allowed; count is unchanged.
- On fetch:
  - Write {pc, ir, rvc} at the tail.
  - pc <= pc + (rvc ? 2 : 4), 64-bit wrap.
  - rvc = (ir[1:0] != 2'b11) when the feature is enabled, else 0.
- When not fetching, pc holds its value. This is mandatory whenever stall_imem=1.
- Output latency:
  - id_* are registered FIFO head outputs; an instruction fetched in cycle N is visible at id_* in cycle N+1.
  - id_valid = (count!=0).
  - id_* hold stable while id_valid && !id_ready.
- FIFO:
  - Head and tail pointers of width log2(FIFO_DEPTH) wrap modulo depth.
  - count is 0..FIFO_DEPTH.
  - Pop on empty is ignored.
- Redirect, when stall_imem=0 in the redirect cycle:
  - FIFO flushed (count=0, pointers=0).
  - pc <= redirect_pc, with bit0 forced 0 (bits[1:0] forced 0 without the feature).
  - The ir sampled this cycle is discarded.
  - id_valid=0 next cycle.
  - Redirect has priority over push and pop.
- Redirect while stall_imem=1:
  - Flush the FIFO immediately.
  - Latch the target into rd_pc and set rd_pend=1. pc stays unchanged, so the refill completes for the old address.
  - In the first cycle with stall_imem=0: pc <= rd_pc, rd_pend=0, no push that cycle.
- A new redirect while rd_pend=1 overwrites rd_pc; last one wins.
- fetch_busy = stall_imem || rd_pend.
- State summary, 2-state FSM:
  - RUN → (redirect && stall_imem) → REDIR.
  - REDIR → (!stall_imem) → RUN, applying rd_pc.
  - REDIR + redirect → REDIR, with rd_pc updated.

Optional Feature:
- FETCH_RVC_EN defined:
  - Compressed detection is active and the PC advances by 2 for 16-bit instructions.
  - id_ir = {16'b0, ir[15:0]} for compressed instructions.
  - Redirect targets keep bit1.
- Not defined:
  - Every instruction is treated as 32-bit; id_rvc is tied to 0.
  - pc always advances by 4.
  - Redirect targets are word-aligned (bits[1:0] cleared).

Test Plan:
1. Reset, stall_imem=0, id_ready=1, ir=32'h00000013 every cycle → pc 0x80000000, 0x80000004, 0x80000008; id_pc lags by one cycle, id_valid=1 from cycle 2.
2. id_ready=0 with FIFO_DEPTH=2 → exactly 2 pushes, then pc frozen at 0x80000008; id_pc=0x80000000 held stable. Raise id_ready → one pop per cycle and fetching resumes, with no instruction lost or duplicated.
3. stall_imem=1 for 10 cycles with a redirect to 0x80001000 in cycle 3 → pc stays 0x80000004 until stall drops. FIFO empties in cycle 4. The first push after stall drop is at pc 0x80001000, one cycle later.
4. Two redirects while stalled (0x2000 then 0x3000) → only 0x3000 is fetched; no instruction from 0x2000 appears at id_*.
5. FETCH_RVC_EN, ir=32'h00004501 then 32'h00000013 → pc 0x80000000 → 0x80000002 → 0x80000006; id_rvc=1 then 0; id_ir=32'h00004501. Without the macro: step +4, id_rvc=0.
6. Full FIFO, simultaneous push+pop+redirect → FIFO empty next cycle, id_valid=0, pc=redirect_pc.
